// File: rtl/tile_select_input.sv
// Board-pin front end for the tile game: synchronises and debounces KEY/SW,
// emits one-cycle select pulses and latches a validated tile pick on each pulse.
module tile_select_input #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int NUM_TILES       = 10
) (
    input  logic                 CLOCK_50,
    input  logic                 clear,
    input  logic [1:0]           KEY,
    input  logic [NUM_TILES-1:0] SW,
    input  logic [NUM_TILES-1:0] lockedMask,
    output logic                 select1,
    output logic                 select2,
    output logic [NUM_TILES-1:0] swClean,
    output logic                 pickValid,
    output logic                 pickError,
    output logic [3:0]           pickIndex,
    output logic [NUM_TILES-1:0] pickOneHot
);
    localparam int CW   = $clog2(DEBOUNCE_CYCLES);
    localparam int POPW = $clog2(NUM_TILES + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]   CNT_ONE = CW'(1);
    localparam logic [POPW-1:0] POP_ONE = POPW'(1);

    typedef enum logic [1:0] {
        REL_WAIT   = 2'd0,
        IDLE       = 2'd1,
        PRESS_WAIT = 2'd2,
        HELD       = 2'd3
    } key_state_t;

    logic [1:0]           key_meta_q, key_sync_q;
    logic [NUM_TILES-1:0] sw_meta_q, sw_sync_q, sw_prev_q, sw_clean_q;
    logic [CW-1:0]        sw_cnt_q;
    logic [1:0]           key_qual;

    always_ff @(posedge CLOCK_50) begin
        if (!clear) begin
            key_meta_q <= 2'b11;
            key_sync_q <= 2'b11;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            sw_prev_q  <= '0;
            sw_cnt_q   <= '0;
            sw_clean_q <= '0;
        end else begin
            key_meta_q <= KEY;
            key_sync_q <= key_meta_q;
            sw_meta_q  <= SW;
            sw_sync_q  <= sw_meta_q;
            sw_prev_q  <= sw_sync_q;
            // Any change in the switch vector restarts the shared stability count.
            if (sw_sync_q != sw_prev_q)
                sw_cnt_q <= '0;
            else if (sw_cnt_q == CNT_MAX)
                sw_clean_q <= sw_sync_q;
            else
                sw_cnt_q <= sw_cnt_q + CNT_ONE;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_key
            key_state_t    state_q, state_d;
            logic [CW-1:0] cnt_q, cnt_d;
            logic          qual;

            always_ff @(posedge CLOCK_50) begin
                if (!clear) begin
                    state_q <= REL_WAIT;
                    cnt_q   <= '0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                end
            end

            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                qual    = 1'b0;
                case (state_q)
                    REL_WAIT: begin
                        if (key_sync_q[gi]) begin
                            if (cnt_q == CNT_MAX) begin
                                state_d = IDLE;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_q + CNT_ONE;
                            end
                        end else begin
                            cnt_d = '0;
                        end
                    end
                    IDLE: begin
                        if (!key_sync_q[gi]) begin
                            state_d = PRESS_WAIT;
                            cnt_d   = CNT_ONE;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!key_sync_q[gi]) begin
                            if (cnt_q == CNT_MAX) begin
                                state_d = HELD;
                                cnt_d   = '0;
                                qual    = 1'b1;
                            end else begin
                                cnt_d = cnt_q + CNT_ONE;
                            end
                        end else begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end
                    end
                    HELD: begin
                        if (key_sync_q[gi]) begin
                            state_d = REL_WAIT;
                            cnt_d   = CNT_ONE;
                        end
                    end
                    default: begin
                        state_d = REL_WAIT;
                        cnt_d   = '0;
                    end
                endcase
            end

            assign key_qual[gi] = qual;
        end
    endgenerate

    // KEY[0] wins a same-cycle tie; KEY[1] still latches HELD and needs a re-press.
    logic select1_d, select2_d, select1_q, select2_q;
    assign select1_d = key_qual[0];
    assign select2_d = key_qual[1] & ~key_qual[0];

    logic [NUM_TILES-1:0] cand;
    logic [POPW-1:0]      cand_cnt;
    logic [3:0]           cand_idx;

    assign cand = sw_clean_q & ~lockedMask;

    always_comb begin
        cand_cnt = '0;
        cand_idx = 4'hF;
        for (int i = 0; i < NUM_TILES; i++) begin
            if (cand[i]) begin
                cand_cnt = cand_cnt + POP_ONE;
                cand_idx = 4'(i);
            end
        end
    end

    logic                 pick_valid_q, pick_error_q;
    logic [3:0]           pick_index_q;
    logic [NUM_TILES-1:0] pick_onehot_q;

    always_ff @(posedge CLOCK_50) begin
        if (!clear) begin
            select1_q     <= 1'b0;
            select2_q     <= 1'b0;
            pick_valid_q  <= 1'b0;
            pick_error_q  <= 1'b0;
            pick_index_q  <= 4'hF;
            pick_onehot_q <= '0;
        end else begin
            select1_q <= select1_d;
            select2_q <= select2_d;
            if (select1_d || select2_d) begin
                if (cand_cnt == POP_ONE) begin
                    pick_valid_q  <= 1'b1;
                    pick_error_q  <= 1'b0;
                    pick_index_q  <= cand_idx;
                    pick_onehot_q <= cand;
                end else begin
                    pick_valid_q  <= 1'b0;
                    pick_error_q  <= 1'b1;
                    pick_index_q  <= 4'hF;
                    pick_onehot_q <= '0;
                end
            end
        end
    end

    assign select1    = select1_q;
    assign select2    = select2_q;
    assign swClean    = sw_clean_q;
    assign pickValid  = pick_valid_q;
    assign pickError  = pick_error_q;
    assign pickIndex  = pick_index_q;
    assign pickOneHot = pick_onehot_q;

endmodule
